// File: rtl/fifo_frame_reader.sv
// Read-side drain engine: pulls samples from the audio FIFO and re-emits them
// as framed valid/ready beats through a 2-entry output buffer.
module fifo_frame_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_LEN  = 1024
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic [15:0]           frame_cnt,
    output logic                  gap_flag,
    input  logic                  gap_clr
);
    localparam int unsigned      CNT_W   = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                             state;
    state_t                             state_nxt;
    logic [CNT_W-1:0]                   rd_cnt;
    logic [CNT_W-1:0]                   beat_cnt;
    logic [1:0][DATA_WIDTH-1:0]         slot;
    logic                               wr_ptr;
    logic                               rd_ptr;
    logic [1:0]                         occ;
    logic                               inflight;
    logic                               pop;
    logic                               push;
    logic                               last_pop;
    logic                               rd_wrap;
    logic                               gap_set;
    logic [2:0]                         level;

    assign m_valid  = (occ != 2'd0);
    assign m_data   = slot[rd_ptr];
    assign m_last   = m_valid && (beat_cnt == CNT_MAX);
    assign pop      = m_valid && m_ready;
    assign push     = inflight;
    assign last_pop = pop && m_last;
    assign busy     = (state != IDLE);
    assign gap_set  = (state == RUN) && (rd_cnt != '0) && rd_empty;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Reads are issued only in RUN and only while buffer + in-flight stays below 2 after this cycle's pop
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        level     = 3'(occ) + 3'(inflight);
        if ((state == RUN) && !rd_empty && (level < (3'd2 + 3'(pop))))
            rd_en = 1'b1;
        rd_wrap   = rd_en && (rd_cnt == CNT_MAX);
        case (state)
            IDLE:    if (enable && !rd_empty) state_nxt = RUN;
            RUN:     if (rd_wrap && !enable)  state_nxt = DRAIN;
            DRAIN:   if (last_pop)            state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_cnt    <= '0;
            beat_cnt  <= '0;
            inflight  <= 1'b0;
            frame_cnt <= 16'd0;
            gap_flag  <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (rd_en)    rd_cnt   <= rd_wrap ? '0 : rd_cnt + 1'b1;
            if (pop)      beat_cnt <= m_last  ? '0 : beat_cnt + 1'b1;
            if (last_pop) frame_cnt <= frame_cnt + 16'd1;
            // A starvation event in the same cycle as a clear keeps the flag set
            if (gap_set)      gap_flag <= 1'b1;
            else if (gap_clr) gap_flag <= 1'b0;
        end
    end

    // Two-entry ring: data returned by the FIFO lands at the tail one cycle after rd_en
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            slot   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= rd_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (push && !pop)      occ <= occ + 2'd1;
            else if (pop && !push) occ <= occ - 2'd1;
        end
    end

    a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
        !(push && !pop && (occ == 2'd2)));

endmodule
